// File: rtl/trackball_counter.sv
// Dual-axis trackball quadrature-style counter: synchronizes and glitch-filters each axis
// clock, counts on filtered rising edges, and offers a registered read port.
module trackball_counter #(
    parameter int unsigned COUNT_WIDTH   = 8,
    parameter int unsigned FILTER_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   h_dir,
    input  logic                   h_clk,
    input  logic                   v_dir,
    input  logic                   v_clk,
    input  logic                   flip,
    input  logic                   rd,
    input  logic                   sel,
    output logic [COUNT_WIDTH-1:0] dout,
    output logic                   dout_valid,
    output logic [COUNT_WIDTH-1:0] h_count,
    output logic [COUNT_WIDTH-1:0] v_count,
    output logic                   h_step,
    output logic                   v_step
);

    localparam logic [3:0]             StabMax  = 4'(FILTER_CYCLES);
    localparam logic [COUNT_WIDTH-1:0] CountOne = COUNT_WIDTH'(1);

    // Bit order: [0] h_clk, [1] h_dir, [2] v_clk, [3] v_dir
    logic [3:0] sync1_q, sync2_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {v_dir, v_clk, h_dir, h_clk};
            sync2_q <= sync1_q;
        end
    end

    for (genvar a = 0; a < 2; a++) begin : g_axis
        logic                   clk_s, dir_s;
        logic                   filt_q, filt_d;
        logic [3:0]             stab_q, stab_d;
        logic                   rise_q, rise_d;
        logic                   dir_q, dir_d;
        logic                   step_q;
        logic [COUNT_WIDTH-1:0] count_q, count_d;

        assign clk_s = sync2_q[2*a];
        assign dir_s = sync2_q[2*a+1];

        // A new level is accepted once it has disagreed with the filtered level for
        // FILTER_CYCLES+1 consecutive samples; the count lands one cycle later.
        always_comb begin
            filt_d  = filt_q;
            stab_d  = stab_q;
            rise_d  = 1'b0;
            dir_d   = dir_q;
            count_d = count_q;
            if (clk_s == filt_q) begin
                stab_d = '0;
            end else if (stab_q == StabMax) begin
                filt_d = clk_s;
                stab_d = '0;
                rise_d = clk_s;
                if (clk_s) begin
                    dir_d = dir_s;
                end
            end else begin
                stab_d = stab_q + 4'd1;
            end
            if (rise_q) begin
                count_d = (dir_q ^ flip) ? count_q - CountOne : count_q + CountOne;
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                filt_q  <= 1'b0;
                stab_q  <= '0;
                rise_q  <= 1'b0;
                dir_q   <= 1'b0;
                step_q  <= 1'b0;
                count_q <= '0;
            end else begin
                filt_q  <= filt_d;
                stab_q  <= stab_d;
                rise_q  <= rise_d;
                dir_q   <= dir_d;
                step_q  <= rise_q;
                count_q <= count_d;
            end
        end
    end

    logic [COUNT_WIDTH-1:0] dout_q, dout_d;
    logic                   dout_valid_q;

    // Reads see the counter value held before this edge's count update
    always_comb begin
        dout_d = dout_q;
        if (rd) begin
            dout_d = sel ? g_axis[1].count_q : g_axis[0].count_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            dout_q       <= dout_d;
            dout_valid_q <= rd;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign h_count    = g_axis[0].count_q;
    assign v_count    = g_axis[1].count_q;
    assign h_step     = g_axis[0].step_q;
    assign v_step     = g_axis[1].step_q;

endmodule

// File: tb/tb_trackball_counter.sv
// Self-checking bench for trackball_counter: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural run-length model.
module tb_trackball_counter;

    localparam int unsigned CW = 8;
    localparam int unsigned FC = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          h_dir = 1'b0, h_clk = 1'b0, v_dir = 1'b0, v_clk = 1'b0;
    logic          flip = 1'b0, rd = 1'b0, sel = 1'b0;
    logic [CW-1:0] dout, h_count, v_count;
    logic          dout_valid, h_step, v_step;

    trackball_counter #(
        .COUNT_WIDTH  (CW),
        .FILTER_CYCLES(FC)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .h_dir     (h_dir),
        .h_clk     (h_clk),
        .v_dir     (v_dir),
        .v_clk     (v_clk),
        .flip      (flip),
        .rd        (rd),
        .sel       (sel),
        .dout      (dout),
        .dout_valid(dout_valid),
        .h_count   (h_count),
        .v_count   (v_count),
        .h_step    (h_step),
        .v_step    (v_step)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model: state after the most recent rising clk edge
    bit            m_f[2];
    int            m_run[2];
    bit            m_pend[2], m_pdir[2], m_step[2];
    logic [CW-1:0] m_cnt[2];
    logic [CW-1:0] m_dout;
    bit            m_dv;
    bit            hq_clk[2][$];
    bit            hq_dir[2][$];
    int            hsteps = 0;

    task automatic model_clear();
        for (int a = 0; a < 2; a++) begin
            m_f[a] = 0; m_run[a] = 0; m_pend[a] = 0; m_pdir[a] = 0; m_step[a] = 0;
            m_cnt[a] = '0;
            hq_clk[a].delete();
            hq_dir[a].delete();
        end
        m_dout = '0;
        m_dv   = 0;
    endtask

    // Inputs are stable at the negedge, so they are exactly what the next posedge samples
    task automatic model_advance();
        bit cin[2];
        bit din[2];
        bit vis, visdir;
        cin[0] = h_clk; cin[1] = v_clk;
        din[0] = h_dir; din[1] = v_dir;
        if (!reset_n) begin
            model_clear();
            return;
        end
        m_dv = rd;
        if (rd) m_dout = m_cnt[sel];
        for (int a = 0; a < 2; a++) begin
            m_step[a] = m_pend[a];
            if (m_pend[a]) m_cnt[a] = (m_pdir[a] ^ flip) ? m_cnt[a] - CW'(1) : m_cnt[a] + CW'(1);
            m_pend[a] = 0;
            hq_clk[a].push_back(cin[a]);
            hq_dir[a].push_back(din[a]);
            if (hq_clk[a].size() > 3) begin
                void'(hq_clk[a].pop_front());
                void'(hq_dir[a].pop_front());
            end
            // The sample taken two edges ago is what the filter sees now
            vis    = (hq_clk[a].size() == 3) ? hq_clk[a][0] : 1'b0;
            visdir = (hq_dir[a].size() == 3) ? hq_dir[a][0] : 1'b0;
            if (vis != m_f[a]) begin
                m_run[a]++;
                if (m_run[a] == int'(FC) + 1) begin
                    m_f[a]   = vis;
                    m_run[a] = 0;
                    if (vis) begin
                        m_pend[a] = 1;
                        m_pdir[a] = visdir;
                    end
                end
            end else begin
                m_run[a] = 0;
            end
        end
    endtask

    initial model_clear();

    always @(negedge clk) begin
        check("h_count", h_count, reset_n ? m_cnt[0] : '0);
        check("v_count", v_count, reset_n ? m_cnt[1] : '0);
        check("h_step", h_step, reset_n ? m_step[0] : 1'b0);
        check("v_step", v_step, reset_n ? m_step[1] : 1'b0);
        check("dout_valid", dout_valid, reset_n ? m_dv : 1'b0);
        check("dout", dout, reset_n ? m_dout : '0);
        if (h_step) hsteps++;
        model_advance();
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input int axis, input int hi, input int lo);
        if (axis == 0) h_clk = 1'b1; else v_clk = 1'b1;
        cyc(hi);
        if (axis == 0) h_clk = 1'b0; else v_clk = 1'b0;
        cyc(lo);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        cyc(3);
        reset_n = 1'b1;
        cyc(2);
    endtask

    // Drives h_clk high from just before edge 0; drops it after edge hi-1 (hi<=0: stays high)
    task automatic watch_step(input int hi, output int first, output int n);
        first = -1;
        n = 0;
        h_clk = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (k == hi - 1) h_clk = 1'b0;
            if (h_step) begin
                n++;
                if (first < 0) first = k;
            end
        end
        h_clk = 1'b0;
        cyc(8);
    endtask

    initial begin
        int base, first, n;
        int hold[2];

        cyc(3);
        check("reset_h_count", h_count, 0);
        check("reset_v_count", v_count, 0);
        check("reset_dout_valid", dout_valid, 0);
        reset_n = 1'b1;
        cyc(4);

        // Ten clean horizontal pulses
        base = hsteps;
        repeat (10) pulse(0, 8, 8);
        cyc(8);
        check("ten_pulses_h_count", h_count, 10);
        check("ten_pulses_h_steps", hsteps - base, 10);
        check("ten_pulses_v_count", v_count, 0);

        // Vertical decrement, then horizontal wrap
        do_reset();
        v_dir = 1'b1;
        cyc(2);
        repeat (3) pulse(1, 8, 8);
        cyc(8);
        check("v_decrement", v_count, 8'hFD);
        h_dir = 1'b0;
        base = hsteps;
        repeat (256) pulse(0, 6, 6);
        cyc(8);
        check("h_wrap", h_count, 0);
        check("h_wrap_steps", hsteps - base, 256);

        // Filter threshold and latency
        watch_step(4, first, n);
        check("short_pulse_no_count", n, 0);
        watch_step(5, first, n);
        check("min_pulse_count", n, 1);
        check("min_pulse_latency", first, 7);
        check("min_pulse_h_count", h_count, 1);

        // Flip inverts subsequent counts only
        do_reset();
        flip = 1'b1;
        cyc(2);
        repeat (2) pulse(0, 8, 8);
        cyc(8);
        check("flip_down", h_count, 8'hFE);
        flip = 1'b0;
        cyc(2);
        repeat (2) pulse(0, 8, 8);
        cyc(8);
        check("flip_up", h_count, 0);

        // Read colliding with a count
        repeat (5) pulse(0, 6, 6);
        cyc(8);
        check("pre_read_h_count", h_count, 5);
        h_clk = 1'b1;
        cyc(6);
        h_clk = 1'b0;
        cyc(1);
        rd = 1'b1;
        sel = 1'b0;
        cyc(1);
        rd = 1'b0;
        check("collide_dout", dout, 5);
        check("collide_valid", dout_valid, 1);
        check("collide_h_count", h_count, 6);
        check("collide_h_step", h_step, 1);
        cyc(1);
        check("valid_one_cycle", dout_valid, 0);
        cyc(6);
        rd = 1'b1;
        cyc(1);
        rd = 1'b0;
        check("next_read_dout", dout, 6);

        // Back-to-back reads switching axis
        rd = 1'b1;
        sel = 1'b0;
        cyc(1);
        check("b2b_read0", dout, 6);
        sel = 1'b1;
        cyc(1);
        check("b2b_read1", dout, 0);
        check("b2b_valid", dout_valid, 1);
        rd = 1'b0;
        sel = 1'b0;
        cyc(1);
        check("b2b_valid_drop", dout_valid, 0);

        // Reset mid-count, then input already high at release
        repeat (29) pulse(0, 6, 6);
        cyc(8);
        check("pre_reset_h_count", h_count, 8'h23);
        h_clk = 1'b1;
        cyc(3);
        reset_n = 1'b0;
        #1;
        check("async_reset_h_count", h_count, 0);
        check("async_reset_h_step", h_step, 0);
        check("async_reset_dout", dout, 0);
        cyc(3);
        reset_n = 1'b1;
        watch_step(0, first, n);
        check("reset_release_count", n, 1);
        check("reset_release_latency", first, 7);
        check("reset_release_h_count", h_count, 1);

        // Randomized traffic against the model
        hold[0] = 0;
        hold[1] = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold[0] == 0) begin
                h_clk = ~h_clk;
                hold[0] = $urandom_range(1, 10);
            end else hold[0]--;
            if (hold[1] == 0) begin
                v_clk = ~v_clk;
                hold[1] = $urandom_range(1, 10);
            end else hold[1]--;
            if ($urandom_range(0, 7) == 0) h_dir = ~h_dir;
            if ($urandom_range(0, 7) == 0) v_dir = ~v_dir;
            if ($urandom_range(0, 63) == 0) flip = ~flip;
            rd  = ($urandom_range(0, 2) == 0);
            sel = 1'($urandom_range(0, 1));
            if (i == 1500) reset_n = 1'b0;
            if (i == 1503) reset_n = 1'b1;
            cyc(1);
        end
        h_clk = 1'b0;
        v_clk = 1'b0;
        rd = 1'b0;
        cyc(12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
